// File: rtl/blit_pkg.sv
// Shared types and helpers for the tile blitter: FSM states, pixel type,
// screen defaults and the source-channel select.
package blit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int unsigned PIX_W_DEF = 12;
    localparam int unsigned SCR_W_DEF = 640;
    localparam int unsigned SCR_H_DEF = 480;
    localparam int unsigned MAX_CH    = 8;

    typedef logic [PIX_W_DEF-1:0] pix_t;

    // Picks channel ch out of a packed bus of up to MAX_CH pixels.
    function automatic pix_t sel_ch(input logic [MAX_CH*PIX_W_DEF-1:0] bus,
                                    input logic [2:0]                  ch);
        return bus[ch*PIX_W_DEF +: PIX_W_DEF];
    endfunction

endpackage

// File: rtl/blit_delay.sv
// LAT-deep shift register aligning issued write metadata with ROM read data.
// Collapses to a plain wire when LAT is zero.
module blit_delay #(
    parameter int unsigned LAT = 1,
    parameter int unsigned W   = 21
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (LAT == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_pipe
            logic [W-1:0] pipe_q [LAT];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int unsigned i = 0; i < LAT; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= d_i;
                    for (int unsigned i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign q_o = pipe_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/tile_blitter.sv
// Tile copy engine: streams one TILE_W x TILE_H tile from a source ROM into
// VRAM with screen clipping. Define BLIT_TRANSPARENT_EN to skip KEY_COLOR pixels.
module tile_blitter
    import blit_pkg::*;
#(
    parameter int unsigned TILE_W    = 32,
    parameter int unsigned TILE_H    = 32,
    parameter int unsigned SRC_CH    = 3,
    parameter int unsigned SCR_W     = SCR_W_DEF,
    parameter int unsigned SCR_H     = SCR_H_DEF,
    parameter int unsigned PIX_W     = PIX_W_DEF,
    parameter int unsigned VADDR_W   = 19,
    parameter int unsigned ROM_LAT   = 1,
    parameter logic [PIX_W-1:0] KEY_COLOR = '0,
    localparam int unsigned SW = (SRC_CH > 1) ? $clog2(SRC_CH) : 1,
    localparam int unsigned AW = $clog2(TILE_W*TILE_H)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [SW-1:0]           cmd_src,
    input  logic [9:0]              cmd_x,
    input  logic [8:0]              cmd_y,
    output logic                    busy,
    output logic                    done,
    output logic [AW-1:0]           src_addr,
    input  logic [SRC_CH*PIX_W-1:0] src_data,
    output logic                    vram_we,
    output logic [VADDR_W-1:0]      vram_addr,
    output logic [PIX_W-1:0]        vram_data
);

    localparam int unsigned CW = $clog2(TILE_W);
    localparam int unsigned RW = $clog2(TILE_H);
    localparam int unsigned DW = VADDR_W + 2;

`ifdef BLIT_TRANSPARENT_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [SW-1:0]      src_q, src_d;
    logic               bad_q, bad_d;
    logic [9:0]         x_q, x_d;
    logic [8:0]         y_q, y_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [VADDR_W-1:0] base_q, base_d;
    logic [1:0]         cnt_q, cnt_d;

    logic               issuing;
    logic               iss_last;
    logic               iss_inb;
    logic [VADDR_W-1:0] iss_addr;
    logic [31:0]        px, py;

    logic [DW-1:0]      dly_in, dly_out;
    logic [VADDR_W-1:0] d_addr;
    logic               d_inb, d_last;

    logic [MAX_CH*PIX_W_DEF-1:0] src_ext;
    pix_t                        pix;
    logic                        is_key;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        bad_d   = bad_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    src_d  = cmd_src;
                    x_d    = cmd_x;
                    y_d    = cmd_y;
                    col_d  = '0;
                    row_d  = '0;
                    base_d = VADDR_W'(cmd_y) * VADDR_W'(SCR_W) + VADDR_W'(cmd_x);
                    cnt_d  = '0;
                    bad_d  = (32'(cmd_src) >= SRC_CH);
                    // An invalid source skips the copy and completes via DRAIN next cycle.
                    state_d = (32'(cmd_src) >= SRC_CH) ? DRAIN : RUN;
                end
            end
            RUN: begin
                col_d = col_q + 1'b1;
                if (col_q == CW'(TILE_W-1)) begin
                    col_d  = '0;
                    row_d  = row_q + 1'b1;
                    base_d = base_q + VADDR_W'(SCR_W);
                end
                if (iss_last) begin
                    state_d = (ROM_LAT > 0) ? DRAIN : IDLE;
                    cnt_d   = 2'(ROM_LAT - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            bad_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            bad_q   <= bad_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
        end
    end

    assign issuing  = (state_q == RUN);
    assign px       = 32'(x_q) + 32'(col_q);
    assign py       = 32'(y_q) + 32'(row_q);
    assign iss_inb  = issuing && (px < SCR_W) && (py < SCR_H);
    assign iss_last = issuing && (row_q == RW'(TILE_H-1)) && (col_q == CW'(TILE_W-1));
    assign iss_addr = issuing ? (base_q + VADDR_W'(col_q)) : '0;
    assign src_addr = issuing ? AW'({row_q, col_q}) : '0;

    assign dly_in = {iss_addr, iss_inb, iss_last};

    blit_delay #(
        .LAT (ROM_LAT),
        .W   (DW)
    ) u_delay (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (dly_in),
        .q_o   (dly_out)
    );

    assign {d_addr, d_inb, d_last} = dly_out;

    assign src_ext = (MAX_CH*PIX_W_DEF)'(src_data);
    assign pix     = sel_ch(src_ext, 3'(src_q));
    assign is_key  = (PIX_W'(pix) == KEY_COLOR);

    assign vram_we   = d_inb && !(TRANSP_EN && is_key);
    assign vram_addr = d_addr;
    assign vram_data = d_inb ? PIX_W'(pix) : '0;

    assign done      = d_last || ((state_q == DRAIN) && bad_q);
    assign busy      = (state_q != IDLE);
    assign cmd_ready = (state_q == IDLE);

endmodule
